qwiledctrl: RTL and testbench
=============================

QWILEDCTRL -- requirements
Module: qwiledctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- CH, 4, LED channel count, 1..16.
- PWID, 8, PWM counter and duty width.
- DIVW, 16, prescaler reload width.
- BWID, 8, blink half-period width.

REQ-002 Ports SHALL be, one per line (clock and reset first):
- sys_clk  in  1  single clock for the whole block.
- sys_rst  in  1  reset, asynchronous, active-high.
- tick_div  in  DIVW  prescaler reload; one tick every tick_div+1 clocks.
- ch_mode  in  2*CH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 on, 10 blink, 11 PWM.
- ch_duty  in  PWID*CH  per-channel PWM duty.
- ch_half  in  BWID*CH  per-channel blink half-period, in PWM periods minus one.
- cfg_load  in  1  one-cycle request to apply ch_mode, ch_duty and ch_half.
- cfg_busy  out  1  load pending, not yet applied.
- cfg_ack  out  1  one-cycle pulse when a load has been applied.
- led  out  CH  registered LED drive, 1 = lit.

Function
REQ-003 The prescaler SHALL count div_cnt from 0 to tick_div, assert an internal tick in the cycle div_cnt==tick_div, and wrap to 0.
- tick_div=0 SHALL give a tick every clock.
- If tick_div is lowered below div_cnt, the next clock SHALL wrap div_cnt to 0 without a tick.
REQ-004 pwm_cnt (PWID bits) SHALL increment on each tick and wrap from 2^PWID-1 to 0.
- A boundary is a tick with pwm_cnt==2^PWID-1.
REQ-005 The active config (mode, duty, half per channel) SHALL change only at a boundary. Inputs SHALL be ignored between loads.
REQ-006 cfg_load SHALL set a pending flag. cfg_busy SHALL equal the pending flag.
REQ-007 At a boundary with pending set, or with cfg_load high in that same cycle, the block SHALL:
- copy the current inputs into the active config,
- clear pending,
- pulse cfg_ack high for exactly the next cycle.
REQ-008 Repeated cfg_load while pending SHALL merge into one load using the inputs present at the applying boundary.
REQ-009 Each channel SHALL own a blink counter (BWID bits) and a blink state bit.
- Both SHALL clear to 0 on every applied load.
- In blink mode, at each boundary: if the counter equals the active half, the blink state SHALL toggle and the counter SHALL clear; otherwise the counter SHALL increment.
REQ-010 Next LED value per channel by mode:
- off: 0.
- on: 1.
- blink: blink state.
- PWM: (pwm_cnt < duty) as unsigned compare, so duty=0 is never lit and duty=2^PWID-1 is lit for 2^PWID-1 of every 2^PWID ticks.
REQ-011 led SHALL be registered, one cycle of latency from pwm_cnt, the active config and the blink state.
REQ-012 Channels SHALL be fully independent except for the shared prescaler, pwm_cnt and load timing.

Reset
REQ-013 While sys_rst is high, all of the following SHALL be 0 immediately and asynchronously: div_cnt, pwm_cnt, pending, cfg_busy, cfg_ack, led, all active modes (off), all duties, all halves, all blink counters and all blink states.
REQ-014 Release of sys_rst SHALL discard any load pending at assertion. The first tick SHALL occur tick_div+1 clocks after release.
REQ-015 Reset asserted mid-period or mid-blink SHALL leave no residual state after release.

Verification
REQ-016 Bench SHALL cover:
- Basic PWM: CH=4, PWID=8, tick_div=0, cfg_load with ch0 mode 11 duty 64 -> after the next boundary, led[0] is high for exactly 64 of every 256 clocks; led[3:1]=0.
- Blink: tick_div=1, ch1 mode 10 half 2 -> led[1] toggles every 3 PWM periods (1536 clocks); the first high starts 3 periods after the applying boundary.
- Load timing: cfg_load mid-period -> cfg_busy=1 until the boundary; cfg_ack pulses once in the next cycle; two cfg_load pulses in one period give one cfg_ack.
- Simultaneous cases: cfg_load in the same cycle as a boundary -> applied at that boundary, cfg_busy never seen high. Duty 0 -> led constant 0. Duty 255 -> low for 1 tick per period.
- Reset mid-operation: sys_rst asserted for 1 cycle during blink high with a pending load -> led=0 and cfg_busy=0 at once; after release all channels stay off and no cfg_ack appears until a new cfg_load.
- tick_div changed from 100 to 3 while div_cnt=50 -> div_cnt wraps to 0 with no tick; ticks then follow every 4 clocks.

Source files
------------

// File: rtl/qwiledctrl.sv
// ---------------------------------------------------------------------------
// qwiledctrl - multi-channel LED controller (off / on / blink / PWM)
//
// A shared prescaler produces a tick every tick_div+1 clocks. Each tick
// advances a shared PWM counter. The tick on which the PWM counter wraps
// (pwm_cnt == all ones) is the "boundary". Per-channel configuration and
// blink timing only ever change at a boundary, so an LED never glitches
// mid-period.
//
// Ports
//   sys_clk   : clock
//   sys_rst   : asynchronous active-high reset
//   tick_div  : prescaler reload (tick every tick_div+1 clocks)
//   ch_mode   : 2 bits per channel, 00 off, 01 on, 10 blink, 11 PWM
//   ch_duty   : PWID bits per channel, PWM duty
//   ch_half   : BWID bits per channel, blink half-period in PWM periods - 1
//   cfg_load  : one-cycle request to apply ch_mode/ch_duty/ch_half
//   cfg_busy  : a load is pending and not yet applied
//   cfg_ack   : one-cycle pulse in the cycle after a load was applied
//   led       : registered LED drive, 1 = lit
//
// Load handshake: cfg_load is a fire-and-forget request that may be
// pulsed at any time. It sets cfg_busy, which stays high until the next
// boundary copies the inputs present in that cycle into the active config;
// cfg_ack then pulses for exactly one cycle. Further requests while busy
// merge into the same load. A request arriving in the boundary cycle
// itself is applied immediately and cfg_busy never rises.
// ---------------------------------------------------------------------------
module qwiledctrl #(
    parameter int CH   = 4,
    parameter int PWID = 8,
    parameter int DIVW = 16,
    parameter int BWID = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [DIVW-1:0]     tick_div,
    input  logic [2*CH-1:0]     ch_mode,
    input  logic [PWID*CH-1:0]  ch_duty,
    input  logic [BWID*CH-1:0]  ch_half,
    input  logic                cfg_load,
    output logic                cfg_busy,
    output logic                cfg_ack,
    output logic [CH-1:0]       led
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PWM   = 2'b11;

    logic [DIVW-1:0]           div_cnt_q, div_cnt_d;
    logic [PWID-1:0]           pwm_cnt_q, pwm_cnt_d;
    logic                      pending_q, pending_d;
    logic                      ack_q, ack_d;
    logic [CH-1:0][1:0]        mode_q, mode_d;
    logic [CH-1:0][PWID-1:0]   duty_q, duty_d;
    logic [CH-1:0][BWID-1:0]   half_q, half_d;
    logic [CH-1:0][BWID-1:0]   bcnt_q, bcnt_d;
    logic [CH-1:0]             bstate_q, bstate_d;
    logic [CH-1:0]             led_q, led_d;

    logic tick;
    logic boundary;
    logic apply;

    always_comb begin
        // Tick on equality; a count above a freshly lowered reload wraps
        // silently so the new rate starts from a clean phase.
        tick      = (div_cnt_q == tick_div);
        div_cnt_d = (div_cnt_q >= tick_div) ? '0 : div_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        boundary  = tick && (pwm_cnt_q == '1);
        apply     = boundary && (pending_q || cfg_load);
        pending_d = apply ? 1'b0 : (pending_q || cfg_load);
        ack_d     = apply;

        mode_d   = mode_q;
        duty_d   = duty_q;
        half_d   = half_q;
        bcnt_d   = bcnt_q;
        bstate_d = bstate_q;
        led_d    = '0;

        for (int i = 0; i < CH; i++) begin
            if (apply) begin
                mode_d[i]   = ch_mode[2*i +: 2];
                duty_d[i]   = ch_duty[PWID*i +: PWID];
                half_d[i]   = ch_half[BWID*i +: BWID];
                bcnt_d[i]   = '0;
                bstate_d[i] = 1'b0;
            end else if (boundary && (mode_q[i] == MODE_BLINK)) begin
                if (bcnt_q[i] == half_q[i]) begin
                    bcnt_d[i]   = '0;
                    bstate_d[i] = ~bstate_q[i];
                end else begin
                    bcnt_d[i] = bcnt_q[i] + 1'b1;
                end
            end

            // LED follows the config that is active this cycle; a new
            // config shows up one cycle after it is applied.
            case (mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = bstate_q[i];
                MODE_PWM:   led_d[i] = (pwm_cnt_q < duty_q[i]);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            mode_q    <= '0;
            duty_q    <= '0;
            half_q    <= '0;
            bcnt_q    <= '0;
            bstate_q  <= '0;
            led_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            mode_q    <= mode_d;
            duty_q    <= duty_d;
            half_q    <= half_d;
            bcnt_q    <= bcnt_d;
            bstate_q  <= bstate_d;
            led_q     <= led_d;
        end
    end

    assign cfg_busy = pending_q;
    assign cfg_ack  = ack_q;
    assign led      = led_q;

endmodule

// File: tb/tb_qwiledctrl.sv
`timescale 1ns/1ps
module tb_qwiledctrl;
  localparam int CH   = 4;
  localparam int PWID = 8;
  localparam int DIVW = 16;
  localparam int BWID = 8;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic [DIVW-1:0]     tick_div = '0;
  logic [2*CH-1:0]     ch_mode = '0;
  logic [PWID*CH-1:0]  ch_duty = '0;
  logic [BWID*CH-1:0]  ch_half = '0;
  logic                cfg_load = 1'b0;
  logic                cfg_busy;
  logic                cfg_ack;
  logic [CH-1:0]       led;

  qwiledctrl #(.CH(CH), .PWID(PWID), .DIVW(DIVW), .BWID(BWID)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .tick_div (tick_div),
    .ch_mode  (ch_mode),
    .ch_duty  (ch_duty),
    .ch_half  (ch_half),
    .cfg_load (cfg_load),
    .cfg_busy (cfg_busy),
    .cfg_ack  (cfg_ack),
    .led      (led)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;
  int ph = 0;   // pwm_cnt after the last edge while tick_div == 0
  int n = 0;    // edges since reset release for hand sequences
  logic [15:0] exp_q[$];

  typedef struct {
    logic [2*CH-1:0]    mode;
    logic [PWID*CH-1:0] duty;
    logic [BWID*CH-1:0] half;
    logic [CH-1:0][8:0] exp_cnt;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic clk1();
    @(posedge sys_clk);
    #1;
    ph = (ph + 1) % 256;
  endtask

  task automatic stepn();
    @(posedge sys_clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int target);
    while (n < target) stepn();
  endtask

  task automatic do_reset(input logic [DIVW-1:0] div);
    sys_rst  = 1'b1;
    cfg_load = 1'b0;
    tick_div = div;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    ph = 0;
    n  = 0;
  endtask

  // Pulse cfg_load mid-period; returns at the sample one edge after the
  // applying boundary edge (ph == 1).
  task automatic apply_cfg(input logic [2*CH-1:0] m, input logic [PWID*CH-1:0] d,
                           input logic [BWID*CH-1:0] h);
    int bad;
    while (ph != 100) clk1();
    ch_mode  = m;
    ch_duty  = d;
    ch_half  = h;
    cfg_load = 1'b1;
    clk1();
    cfg_load = 1'b0;
    check("busy_after_load", cfg_busy, 1);
    bad = 0;
    while (ph != 0) begin
      if (cfg_busy !== 1'b1 || cfg_ack !== 1'b0) bad++;
      clk1();
    end
    check("busy_held_until_boundary", bad, 0);
    check("ack_at_boundary", cfg_ack, 1);
    check("busy_clear_at_boundary", cfg_busy, 0);
    clk1();
    check("ack_one_cycle", cfg_ack, 0);
  endtask

  // Count lit samples per channel over one full PWM period, starting at
  // ph == 1, and compare against the scoreboard.
  task automatic measure(input string tag);
    int cnt[CH];
    for (int c = 0; c < CH; c++) cnt[c] = 0;
    // Inputs are scrambled without a load; they must have no effect.
    ch_mode = 8'($urandom);
    ch_duty = 32'($urandom);
    ch_half = 32'($urandom);
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < CH; c++) cnt[c] += int'(led[c]);
      clk1();
    end
    for (int c = 0; c < CH; c++) begin
      logic [15:0] e;
      if (exp_q.size() == 0) begin
        check({tag, "_scoreboard_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s_ch%0d_lit", tag, c), cnt[c], e);
      end
    end
  endtask

  task automatic push_exp(input logic [CH-1:0][8:0] e);
    for (int c = 0; c < CH; c++) exp_q.push_back(16'(e[c]));
  endtask

  initial begin
    logic [7:0] d0, d1, d2, d3;
    int bad;
    int acks;
    int t;

    // stimulus table
    tbl[0].mode    = 8'b00_00_00_11;
    tbl[0].duty    = {8'd0, 8'd0, 8'd0, 8'd64};
    tbl[0].half    = '0;
    tbl[0].exp_cnt = {9'd0, 9'd0, 9'd0, 9'd64};
    tbl[1].mode    = 8'b11_11_11_01;
    tbl[1].duty    = {8'd128, 8'd255, 8'd0, 8'd0};
    tbl[1].half    = '0;
    tbl[1].exp_cnt = {9'd128, 9'd255, 9'd0, 9'd256};
    tbl[2].mode    = 8'b11_01_10_11;
    tbl[2].duty    = {8'd200, 8'd0, 8'd0, 8'd1};
    tbl[2].half    = '0;
    tbl[2].exp_cnt = {9'd200, 9'd256, 9'd0, 9'd1};
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    d3 = 8'($urandom_range(0, 255));
    tbl[3].mode    = 8'b11_11_11_11;
    tbl[3].duty    = {d3, d2, d1, d0};
    tbl[3].half    = '0;
    tbl[3].exp_cnt = {1'b0, d3, 1'b0, d2, 1'b0, d1, 1'b0, d0};

    // reset state
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_led", led, 0);
    check("reset_busy", cfg_busy, 0);
    check("reset_ack", cfg_ack, 0);
    do_reset(0);

    // table-driven loads, tick_div = 0
    for (int e = 0; e < 4; e++) begin
      push_exp(tbl[e].exp_cnt);
      apply_cfg(tbl[e].mode, tbl[e].duty, tbl[e].half);
      measure($sformatf("vec%0d", e));
    end

    // two loads in one period merge into one, using the later inputs
    while (ph != 50) clk1();
    ch_mode = 8'b00_00_00_11; ch_duty = {24'd0, 8'd10}; ch_half = '0;
    cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    while (ph != 150) clk1();
    ch_mode = 8'b00_01_01_11; ch_duty = {24'd0, 8'd30};
    cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    acks = 0;
    while (ph != 1) begin
      acks += int'(cfg_ack);
      clk1();
    end
    acks += int'(cfg_ack);
    check("merge_single_ack", acks, 1);
    push_exp({9'd0, 9'd256, 9'd256, 9'd30});
    measure("merge");

    // cfg_load in the boundary cycle itself
    while (ph != 255) clk1();
    ch_mode = 8'b01_10_11_11; ch_duty = {8'd0, 8'd0, 8'd0, 8'd255}; ch_half = {8'd0, 8'd5, 16'd0};
    cfg_load = 1'b1; clk1(); cfg_load = 1'b0;
    check("simul_busy_never", cfg_busy, 0);
    check("simul_ack", cfg_ack, 1);
    clk1();
    check("simul_ack_one_cycle", cfg_ack, 0);
    push_exp({9'd256, 9'd0, 9'd0, 9'd255});
    measure("simul");

    // tick_div lowered from 100 to 3 while div_cnt == 50
    apply_cfg(8'b00_00_11_11, {16'd0, 8'd3, 8'd2}, '0);
    tick_div = 16'd100;
    ch_mode = '0;
    for (t = 0; t < 50; t++) clk1();
    tick_div = 16'd3;
    while (t < 61) begin
      clk1();
      t++;
      if (t == 52) check("div_wrap_no_tick", led, 4'b0011);
      if (t == 55) check("div_first_tick_pre", led, 4'b0011);
      if (t == 56) check("div_first_tick", led, 4'b0010);
      if (t == 59) check("div_second_tick_pre", led, 4'b0010);
      if (t == 60) check("div_second_tick", led, 4'b0000);
    end

    // blink, tick_div = 1: boundaries at edges 512, 1024, 1536, 2048, ...
    do_reset(1);
    step_to(10);
    ch_mode = 8'b00_00_10_00; ch_duty = '0; ch_half = {16'd0, 8'd2, 8'd0};
    cfg_load = 1'b1; stepn(); cfg_load = 1'b0;
    check("blink_busy", cfg_busy, 1);
    step_to(512);
    check("blink_ack", cfg_ack, 1);
    check("blink_busy_clear", cfg_busy, 0);
    step_to(2048);
    check("blink_low_before_first", led, 4'b0000);
    stepn();
    check("blink_first_high", led, 4'b0010);
    step_to(2100);

    // reset during blink high with a load pending
    ch_mode = 8'b00_00_10_01;
    cfg_load = 1'b1; stepn(); cfg_load = 1'b0;
    check("rst_pre_busy", cfg_busy, 1);
    check("rst_pre_led", led, 4'b0010);
    sys_rst = 1'b1;
    #1;
    check("rst_async_led", led, 0);
    check("rst_async_busy", cfg_busy, 0);
    check("rst_async_ack", cfg_ack, 0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    n = 0;
    bad = 0;
    while (n < 1100) begin
      if (led !== 4'b0000 || cfg_ack !== 1'b0 || cfg_busy !== 1'b0) bad++;
      stepn();
    end
    check("rst_no_residual", bad, 0);
    cfg_load = 1'b1; stepn(); cfg_load = 1'b0;
    bad = 0;
    while (cfg_ack !== 1'b1 && bad < 600) begin
      stepn();
      bad++;
    end
    check("post_rst_ack_edge", n, 1536);
    stepn();
    check("post_rst_led", led, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
